// File: rtl/home_sensor_frontend.sv
// -----------------------------------------------------------------------------
// home_sensor_frontend
//
// Sensor-side producer of the motion / dark / color_select triple consumed by
// the lamp controller. The raw PIR sensor and wall button are synchronised and
// debounced. Motion is stretched into an occupancy window with a hold timeout.
// The ambient-light sample is thresholded with hysteresis. Each button press
// steps color_select. All outputs are registered.
//
// Occupancy FSM states:
//   state       | meaning
//   ------------+------------------------------------------------------------
//   ST_IDLE     | room empty, motion=0
//   ST_OCCUPIED | debounced PIR active, motion=1
//   ST_HOLD     | PIR released, hold_cnt counting down to 0, motion=1
//
// Ports:
//   clk           in   1        system clock, rising edge
//   rst           in   1        synchronous reset, active-high
//   pir_raw       in   1        asynchronous PIR sensor level
//   btn_raw       in   1        asynchronous colour button, 1 = pressed
//   light_level   in   LIGHT_W  ambient light sample, larger = brighter
//   light_valid   in   1        light_level is qualified this cycle
//   motion        out  1        occupancy (registered)
//   dark          out  1        darkness flag (registered)
//   color_select  out  3        colour code to the lamp controller (registered)
//   color_change  out  1        one-cycle pulse when color_select updates
// -----------------------------------------------------------------------------
module home_sensor_frontend #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 1000,
    parameter int LIGHT_W         = 8,
    parameter int DARK_ON         = 40,
    parameter int DARK_OFF        = 60,
    parameter int NUM_COLORS      = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pir_raw,
    input  logic               btn_raw,
    input  logic [LIGHT_W-1:0] light_level,
    input  logic               light_valid,
    output logic               motion,
    output logic               dark,
    output logic [2:0]         color_select,
    output logic               color_change
);

    localparam int                  DB_W       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0]     DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam int                  HOLD_W     = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0]   HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [LIGHT_W-1:0]  DARK_ON_L  = LIGHT_W'(DARK_ON);
    localparam logic [LIGHT_W-1:0]  DARK_OFF_L = LIGHT_W'(DARK_OFF);
    localparam logic [2:0]          COLOR_LAST = 3'(NUM_COLORS - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_OCCUPIED = 2'd1,
        ST_HOLD     = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Two-flop synchronisers
    // -------------------------------------------------------------------------
    logic pir_s1, pir_s2;
    logic btn_s1, btn_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            pir_s1 <= 1'b0;
            pir_s2 <= 1'b0;
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
        end else begin
            pir_s1 <= pir_raw;
            pir_s2 <= pir_s1;
            btn_s1 <= btn_raw;
            btn_s2 <= btn_s1;
        end
    end

    // -------------------------------------------------------------------------
    // Debounce: count consecutive synced samples that disagree with the
    // accepted level; any agreeing sample restarts the count. The level flips
    // on the DEBOUNCE_CYCLES-th disagreeing sample.
    // -------------------------------------------------------------------------
    logic            pir_d;
    logic [DB_W-1:0] pir_cnt;
    logic            btn_d;
    logic [DB_W-1:0] btn_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            pir_d   <= 1'b0;
            pir_cnt <= '0;
        end else if (pir_s2 == pir_d) begin
            pir_cnt <= '0;
        end else if (pir_cnt == DB_LAST) begin
            pir_d   <= ~pir_d;
            pir_cnt <= '0;
        end else begin
            pir_cnt <= pir_cnt + DB_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_d   <= 1'b0;
            btn_cnt <= '0;
        end else if (btn_s2 == btn_d) begin
            btn_cnt <= '0;
        end else if (btn_cnt == DB_LAST) begin
            btn_d   <= ~btn_d;
            btn_cnt <= '0;
        end else begin
            btn_cnt <= btn_cnt + DB_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Occupancy FSM
    // -------------------------------------------------------------------------
    state_t            state_q;
    state_t            state_next;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_next;
    logic              motion_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            motion     <= 1'b0;
        end else begin
            state_q    <= state_next;
            hold_cnt_q <= hold_cnt_next;
            motion     <= motion_next;
        end
    end

    // A returning PIR in HOLD takes priority over the timeout, so a re-trigger
    // on the terminal count keeps the lamp on without a dropout.
    always_comb begin
        state_next    = state_q;
        hold_cnt_next = hold_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pir_d) begin
                    state_next = ST_OCCUPIED;
                end
            end
            ST_OCCUPIED: begin
                if (!pir_d) begin
                    state_next    = ST_HOLD;
                    hold_cnt_next = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (pir_d) begin
                    state_next = ST_OCCUPIED;
                end else if (hold_cnt_q == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    hold_cnt_next = hold_cnt_q - HOLD_W'(1);
                end
            end
            default: begin
                state_next    = ST_IDLE;
                hold_cnt_next = '0;
            end
        endcase
    end

    // motion is taken from the next state so it lines up with the state flop.
    always_comb begin
        motion_next = (state_next != ST_IDLE);
    end

    // -------------------------------------------------------------------------
    // Darkness hysteresis; between the thresholds the flag keeps its value.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            dark <= 1'b0;
        end else if (light_valid) begin
            if (light_level <= DARK_ON_L) begin
                dark <= 1'b1;
            end else if (light_level >= DARK_OFF_L) begin
                dark <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Colour stepping on the rising edge of the debounced button.
    // -------------------------------------------------------------------------
    logic btn_d_q;
    logic btn_rise;

    assign btn_rise = btn_d & ~btn_d_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_d_q      <= 1'b0;
            color_select <= 3'd0;
            color_change <= 1'b0;
        end else begin
            btn_d_q      <= btn_d;
            color_change <= btn_rise;
            if (btn_rise) begin
                if (color_select == COLOR_LAST) begin
                    color_select <= 3'd0;
                end else begin
                    color_select <= color_select + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_home_sensor_frontend.sv
module tb_home_sensor_frontend;

    localparam int DB   = 4;
    localparam int HOLD = 10;

    localparam int K_MOTION = 0;
    localparam int K_DARK   = 1;
    localparam int K_COLOR  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pir_raw = 1'b0;
    logic       btn_raw = 1'b0;
    logic [7:0] light_level = 8'd0;
    logic       light_valid = 1'b0;
    logic       motion;
    logic       dark;
    logic [2:0] color_select;
    logic       color_change;

    home_sensor_frontend #(
        .DEBOUNCE_CYCLES (DB),
        .HOLD_CYCLES     (HOLD),
        .LIGHT_W         (8),
        .DARK_ON         (40),
        .DARK_OFF        (60),
        .NUM_COLORS      (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pir_raw      (pir_raw),
        .btn_raw      (btn_raw),
        .light_level  (light_level),
        .light_valid  (light_valid),
        .motion       (motion),
        .dark         (dark),
        .color_select (color_select),
        .color_change (color_change)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected output events. A colour event value is color_select*2+color_change.
    typedef struct {
        int kind;
        int value;
        int when;
    } ev_t;

    ev_t  exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    logic       prev_motion;
    logic       prev_dark;
    logic [2:0] prev_color;

    function automatic string kname(int k);
        case (k)
            K_MOTION: return "motion";
            K_DARK:   return "dark";
            default:  return "color";
        endcase
    endfunction

    task automatic expect_ev(int kind, int value, int when);
        ev_t e;
        e.kind  = kind;
        e.value = value;
        e.when  = when;
        exp_q.push_back(e);
    endtask

    task automatic observe(int kind, int value);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s: got %s=%0d at cycle %0d, required no event",
                     kname(kind), kname(kind), value, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.value != value || e.when != cyc) begin
                errors++;
                $display("FAIL event_%s: got %s=%0d at cycle %0d, required %s=%0d at cycle %0d",
                         kname(e.kind), kname(kind), value, cyc, kname(e.kind), e.value, e.when);
            end
        end
    endtask

    // Monitor: every output change (or color_change pulse) is an event that
    // must match the head of the expected queue.
    always @(negedge clk) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].when < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_%s: got no event by cycle %0d, required %s=%0d at cycle %0d",
                         kname(exp_q[0].kind), cyc, kname(exp_q[0].kind), exp_q[0].value, exp_q[0].when);
                void'(exp_q.pop_front());
            end
            if (motion !== prev_motion) observe(K_MOTION, int'(motion));
            if (dark !== prev_dark) observe(K_DARK, int'(dark));
            if (color_select !== prev_color || color_change !== 1'b0)
                observe(K_COLOR, int'(color_select) * 2 + int'(color_change));
            prev_motion = motion;
            prev_dark   = dark;
            prev_color  = color_select;
        end
    end

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(int n);
        repeat (n) tick();
    endtask

    int col = 0;

    task automatic press(int hold_len);
        int c;
        c = cyc;
        col = (col == 4) ? 0 : col + 1;
        expect_ev(K_COLOR, col * 2 + 1, c + 7);
        btn_raw = 1'b1;
        ticks(hold_len);
        btn_raw = 1'b0;
        ticks(10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int lv[7] = '{100, 50, 40, 50, 59, 60, 45};

        // Reset for three edges; outputs must read 0 throughout.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_motion", motion, 0);
            chk("reset_dark", dark, 0);
            chk("reset_color", color_select, 0);
            chk("reset_change", color_change, 0);
        end
        prev_motion = motion;
        prev_dark   = dark;
        prev_color  = color_select;
        mon_en      = 1'b1;
        rst         = 1'b0;

        // Clean PIR rise: motion 6 edges after the first sampling edge.
        c = cyc;
        pir_raw = 1'b1;
        expect_ev(K_MOTION, 1, c + 7);
        ticks(12);

        // Release: motion holds HOLD cycles after pir_d falls.
        c = cyc;
        pir_raw = 1'b0;
        expect_ev(K_MOTION, 0, c + 17);
        ticks(25);

        // Re-occupy, then re-trigger exactly at hold_cnt==0: no dropout.
        c = cyc;
        pir_raw = 1'b1;
        expect_ev(K_MOTION, 1, c + 7);
        ticks(12);
        pir_raw = 1'b0;
        ticks(10);
        pir_raw = 1'b1;
        ticks(20);
        c = cyc;
        pir_raw = 1'b0;
        expect_ev(K_MOTION, 0, c + 17);
        ticks(25);

        // Glitches one sample short of the debounce length.
        repeat (4) begin
            pir_raw = 1'b1;
            ticks(3);
            pir_raw = 1'b0;
            ticks(3);
        end
        ticks(10);

        // Dark hysteresis sequence.
        c = cyc;
        expect_ev(K_DARK, 1, c + 3);
        expect_ev(K_DARK, 0, c + 6);
        light_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            light_level = 8'(lv[i]);
            tick();
        end
        light_valid = 1'b0;
        light_level = 8'd30;
        ticks(3);
        light_valid = 1'b1;
        light_level = 8'd41;
        tick();
        c = cyc;
        light_level = 8'd40;
        expect_ev(K_DARK, 1, c + 1);
        tick();
        light_valid = 1'b0;
        light_level = 8'd200;
        ticks(3);
        c = cyc;
        light_valid = 1'b1;
        light_level = 8'd61;
        expect_ev(K_DARK, 0, c + 1);
        tick();
        light_valid = 1'b0;
        ticks(3);

        // Six presses, then a long hold giving one step.
        repeat (6) press(8);
        press(50);

        // Simultaneous PIR rise, button press and dark sample.
        c = cyc;
        col = (col == 4) ? 0 : col + 1;
        expect_ev(K_DARK, 1, c + 1);
        expect_ev(K_MOTION, 1, c + 7);
        expect_ev(K_COLOR, col * 2 + 1, c + 7);
        pir_raw     = 1'b1;
        btn_raw     = 1'b1;
        light_valid = 1'b1;
        light_level = 8'd20;
        tick();
        light_valid = 1'b0;
        ticks(7);
        btn_raw = 1'b0;
        ticks(10);

        // Into HOLD, start a button debounce, then reset.
        pir_raw = 1'b0;
        ticks(9);
        btn_raw = 1'b1;
        ticks(3);
        c = cyc;
        rst     = 1'b1;
        btn_raw = 1'b0;
        col     = 0;
        expect_ev(K_MOTION, 0, c + 1);
        expect_ev(K_DARK, 0, c + 1);
        expect_ev(K_COLOR, 0, c + 1);
        tick();
        chk("hold_reset_motion", motion, 0);
        chk("hold_reset_dark", dark, 0);
        chk("hold_reset_color", color_select, 0);
        chk("hold_reset_change", color_change, 0);
        tick();
        rst = 1'b0;
        ticks(30);
        press(8);

        ticks(20);
        while (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL missing_%s: got no event by end, required %s=%0d at cycle %0d",
                     kname(exp_q[0].kind), kname(exp_q[0].kind), exp_q[0].value, exp_q[0].when);
            void'(exp_q.pop_front());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
